// File: rtl/inst_fetch_queue.sv
// Instruction fetch front-end: issues word fetches, buffers {inst, pc} in a FIFO, and flushes on redirect.
// Optional statistics counters are compiled in when IFQ_STATS_EN is defined.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  output logic                     imem_req_o,
  output logic [31:0]              imem_addr_o,
  input  logic [31:0]              imem_rdata_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_inst_o,
  output logic [31:0]              out_pc_o,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef IFQ_STATS_EN
  ,
  output logic [15:0]              flush_cnt_o,
  output logic [15:0]              fetch_cnt_o
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthOcc = (CntW + 1)'(DEPTH);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     tag_pc_q, tag_pc_d;
  logic            inflight_q, inflight_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]     head_inst_q, head_inst_d;
  logic [31:0]     head_pc_q, head_pc_d;

  logic [31:0]     mem_inst_q [DEPTH];
  logic [31:0]     mem_pc_q   [DEPTH];

  logic [CntW:0]   occupancy;
  logic            req;
  logic            push;
  logic            pop;
  logic            valid;

  assign valid     = (cnt_q != '0);
  // Reserve a slot for the in-flight word so a returning response always has room.
  assign occupancy = {1'b0, cnt_q} + (CntW + 1)'(inflight_q);
  assign req       = rst_ni && !redirect_i && (occupancy < DepthOcc);
  assign push      = inflight_q && !redirect_i;
  assign pop       = valid && out_ready_i && !redirect_i;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    tag_pc_d    = tag_pc_q;
    inflight_d  = 1'b0;
    cnt_d       = cnt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    head_inst_d = head_inst_q;
    head_pc_d   = head_pc_q;

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~32'h3;
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tag_pc_d   = fetch_pc_q;
        inflight_d = 1'b1;
      end
      cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      // The head copy tracks whichever entry sits at the read pointer after this edge.
      if (cnt_d != '0) begin
        if (push && (wr_ptr_q == rd_ptr_d)) begin
          head_inst_d = imem_rdata_i;
          head_pc_d   = tag_pc_q;
        end else begin
          head_inst_d = mem_inst_q[rd_ptr_d];
          head_pc_d   = mem_pc_q[rd_ptr_d];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q  <= RESET_PC;
      tag_pc_q    <= '0;
      inflight_q  <= 1'b0;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      head_inst_q <= '0;
      head_pc_q   <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      tag_pc_q    <= tag_pc_d;
      inflight_q  <= inflight_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      head_inst_q <= head_inst_d;
      head_pc_q   <= head_pc_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_inst_q[wr_ptr_q] <= imem_rdata_i;
      mem_pc_q[wr_ptr_q]   <= tag_pc_q;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc_q;
  assign out_valid_o = valid;
  assign out_inst_o  = head_inst_q;
  assign out_pc_o    = head_pc_q;
  assign count_o     = cnt_q;

`ifdef IFQ_STATS_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    if (redirect_i && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    if (push && (fetch_cnt_q != 16'hFFFF))       fetch_cnt_d = fetch_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_cnt_q <= '0;
      fetch_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign flush_cnt_o = flush_cnt_q;
  assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: constant vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  count;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata = '0;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [31:0] w_pc;
  logic [2:0]  w_count;

`ifdef IFQ_STATS_EN
  logic [15:0] flush_cnt, fetch_cnt, w_flush_cnt, w_fetch_cnt;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata <= imem_addr >> 2;
    w_rdata    <= w_addr >> 2;
  end

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_inst_o(out_inst), .out_pc_o(out_pc), .count_o(count)
`ifdef IFQ_STATS_EN
    , .flush_cnt_o(flush_cnt), .fetch_cnt_o(fetch_cnt)
`endif
  );

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_rdata_i(w_rdata),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .out_valid_o(w_valid), .out_ready_i(1'b0),
    .out_inst_o(w_inst), .out_pc_o(w_pc), .count_o(w_count)
`ifdef IFQ_STATS_EN
    , .flush_cnt_o(w_flush_cnt), .fetch_cnt_o(w_fetch_cnt)
`endif
  );

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  // Reference model: pending entries as a PC queue, one outstanding fetch, next fetch PC.
  logic [31:0] q_m[$];
  int          infl_m;
  logic [31:0] tag_m;
  logic [31:0] fetch_m;
  logic        cur_rd;
  logic [31:0] cur_rpc;
  logic        cur_rdy;

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    int unsigned cnt;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t        tbl[10];
  logic [31:0] wrap_exp[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    infl_m  = 0;
    tag_m   = '0;
    fetch_m = 32'h0;
  endtask

  task automatic drive(input logic rd, input logic [31:0] rpc, input logic rdy);
    cur_rd      = rd;
    cur_rpc     = rpc;
    cur_rdy     = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    #1;
  endtask

  task automatic check_model();
    logic req_m;
    req_m = !cur_rd && ((q_m.size() + infl_m) < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(req_m));
    chk("imem_addr", imem_addr, fetch_m);
    chk("count", 32'(count), q_m.size());
    chk("out_valid", 32'(out_valid), 32'(q_m.size() != 0));
    if (q_m.size() != 0) begin
      chk("head_pc", out_pc, q_m[0]);
      chk("head_inst", out_inst, q_m[0] >> 2);
    end
  endtask

  task automatic advance();
    logic req_m;
    req_m = !cur_rd && ((q_m.size() + infl_m) < DEPTH);
    if (cur_rd) begin
      q_m.delete();
      infl_m  = 0;
      fetch_m = cur_rpc & ~32'h3;
    end else begin
      if (cur_rdy && q_m.size() != 0) void'(q_m.pop_front());
      if (infl_m != 0) q_m.push_back(tag_m);
      if (req_m) begin
        infl_m  = 1;
        tag_m   = fetch_m;
        fetch_m = fetch_m + 32'd4;
      end else begin
        infl_m = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
    drive(rd, rpc, rdy);
    check_model();
    advance();
  endtask

  task automatic do_reset();
    @(negedge clk);
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_valid", 32'(out_valid), 32'h0);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;

    //        rdy   req   addr    cnt vld  pc
    tbl[0] = '{1'b0, 1'b1, 32'h00, 0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 32'h04, 0, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 32'h08, 1, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 32'h0C, 2, 1'b1, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 32'h10, 3, 1'b1, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 32'h10, 4, 1'b1, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 32'h10, 4, 1'b1, 32'h0};
    tbl[7] = '{1'b1, 1'b1, 32'h10, 3, 1'b1, 32'h4};
    tbl[8] = '{1'b1, 1'b1, 32'h14, 2, 1'b1, 32'h8};
    tbl[9] = '{1'b1, 1'b1, 32'h18, 2, 1'b1, 32'hC};
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;

    // Fill, then stream, against fixed expectations.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, tbl[i].rdy);
      chk("tbl_req", 32'(imem_req), 32'(tbl[i].req));
      chk("tbl_addr", imem_addr, tbl[i].addr);
      chk("tbl_count", 32'(count), tbl[i].cnt);
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) chk("tbl_pc", out_pc, tbl[i].pc);
      if (i < 3) begin
        chk("wrap_addr", w_addr, wrap_exp[i]);
        chk("wrap_req", 32'(w_req), 32'h1);
      end
      check_model();
      advance();
    end
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

    // Async reset mid-stream clears the queue before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_count", 32'(count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);

    // Redirect while three entries are queued and one fetch is in flight.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h43, 1'b0);
    chk("redir_no_req", 32'(imem_req), 32'h0);
    check_model();
    advance();
    drive(1'b0, 32'h0, 1'b0);
    chk("redir_count", 32'(count), 32'h0);
    chk("redir_valid", 32'(out_valid), 32'h0);
    chk("redir_addr", imem_addr, 32'h40);
    check_model();
    advance();
    step(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    chk("redir_first_pc", out_pc, 32'h40);
    check_model();
    advance();

    // Redirect and pop in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h100, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    chk("redir_pop_count", 32'(count), 32'h0);
    check_model();
    advance();
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);

    // Alternating backpressure.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b0, 32'h0, (i % 2) == 0);

`ifdef IFQ_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h200, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    chk("flush_cnt", 32'(flush_cnt), 32'd3);
    chk("fetch_cnt", 32'(fetch_cnt), 32'd0);
    check_model();
    advance();
`endif

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(15) == 0), $urandom, $urandom_range(1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
